// File: rtl/inv_twiddle_factor.sv
// Inverse twiddle rotation: out = C * conj(T), rounded and saturated.
// Two-stage valid/ready pipeline: S1 holds the four products, S2 holds the result.
module inv_twiddle_factor #(
    parameter int unsigned FRAC  = 10,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [23:0]      C,
    input  logic [23:0]      T,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [23:0]      out,
    output logic             sat_flag,
    output logic [CNT_W-1:0] sat_cnt
);

    localparam int unsigned SW = 26;
    localparam logic signed [SW-1:0] RND = 26'sd1 <<< (FRAC - 1);
    localparam logic signed [SW-1:0] MAXV = 26'sd2047;
    localparam logic signed [SW-1:0] MINV = -26'sd2048;

    logic signed [11:0] cr, ci, tr, ti;

    logic               s1_valid_d, s1_valid_q;
    logic signed [23:0] p_rr_d, p_rr_q;   // Cr*Tr
    logic signed [23:0] p_ii_d, p_ii_q;   // Ci*Ti
    logic signed [23:0] p_ir_d, p_ir_q;   // Ci*Tr
    logic signed [23:0] p_ri_d, p_ri_q;   // Cr*Ti

    logic               out_valid_d, out_valid_q;
    logic [23:0]        out_d, out_q;
    logic               sat_flag_d, sat_flag_q;
    logic [CNT_W-1:0]   sat_cnt_d, sat_cnt_q;

    logic               adv_c;
    logic signed [SW-1:0] sum_r, sum_i, sh_r, sh_i;
    logic [11:0]        o_r, o_i;
    logic               sat_r, sat_i;

    assign cr = C[23:12];
    assign ci = C[11:0];
    assign tr = T[23:12];
    assign ti = T[11:0];

    // Whole pipeline moves together; a stalled output freezes both stages.
    assign adv_c    = !out_valid_q || out_ready;
    assign in_ready = adv_c;

    // Round-half-up and saturate both components of the S1 products.
    always_comb begin
        sum_r = SW'(p_rr_q) + SW'(p_ii_q) + RND;
        sum_i = SW'(p_ir_q) - SW'(p_ri_q) + RND;
        sh_r  = sum_r >>> FRAC;
        sh_i  = sum_i >>> FRAC;
        o_r   = sh_r[11:0];
        o_i   = sh_i[11:0];
        sat_r = 1'b0;
        sat_i = 1'b0;
        if (sh_r > MAXV) begin
            o_r   = 12'h7FF;
            sat_r = 1'b1;
        end else if (sh_r < MINV) begin
            o_r   = 12'h800;
            sat_r = 1'b1;
        end
        if (sh_i > MAXV) begin
            o_i   = 12'h7FF;
            sat_i = 1'b1;
        end else if (sh_i < MINV) begin
            o_i   = 12'h800;
            sat_i = 1'b1;
        end
    end

    // Next-state for both stages and the saturation counter.
    always_comb begin
        s1_valid_d  = s1_valid_q;
        p_rr_d      = p_rr_q;
        p_ii_d      = p_ii_q;
        p_ir_d      = p_ir_q;
        p_ri_d      = p_ri_q;
        out_valid_d = out_valid_q;
        out_d       = out_q;
        sat_flag_d  = sat_flag_q;
        sat_cnt_d   = sat_cnt_q;

        if (out_valid_q && out_ready && sat_flag_q && (sat_cnt_q != '1)) begin
            sat_cnt_d = sat_cnt_q + CNT_W'(1);
        end

        if (adv_c) begin
            s1_valid_d  = in_valid;
            p_rr_d      = cr * tr;
            p_ii_d      = ci * ti;
            p_ir_d      = ci * tr;
            p_ri_d      = cr * ti;
            out_valid_d = s1_valid_q;
            out_d       = {o_r, o_i};
            sat_flag_d  = s1_valid_q && (sat_r || sat_i);
        end
    end

    // Pipeline and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            p_rr_q      <= '0;
            p_ii_q      <= '0;
            p_ir_q      <= '0;
            p_ri_q      <= '0;
            out_valid_q <= 1'b0;
            out_q       <= 24'h000000;
            sat_flag_q  <= 1'b0;
            sat_cnt_q   <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            p_rr_q      <= p_rr_d;
            p_ii_q      <= p_ii_d;
            p_ir_q      <= p_ir_d;
            p_ri_q      <= p_ri_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            sat_flag_q  <= sat_flag_d;
            sat_cnt_q   <= sat_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out       = out_q;
    assign sat_flag  = sat_flag_q;
    assign sat_cnt   = sat_cnt_q;

endmodule

// File: tb/tb_inv_twiddle_factor.sv
// Directed bench for inv_twiddle_factor with hand-computed expectations.
module tb_inv_twiddle_factor;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] c;
    logic [23:0] t;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] dout;
    logic        sat_flag;
    logic [15:0] sat_cnt;

    int checks = 0;
    int passed = 0;

    inv_twiddle_factor #(.FRAC(10), .CNT_W(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .C        (c),
        .T        (t),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out      (dout),
        .sat_flag (sat_flag),
        .sat_cnt  (sat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle before sampling/driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Present one pair for exactly one accepting edge.
    task automatic send(input logic [23:0] cv, input logic [23:0] tv);
        in_valid = 1'b1;
        c        = cv;
        t        = tv;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        c         = 24'h0;
        t         = 24'h0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out",       32'(dout),      32'h000000);
        chk("rst_sat_flag",  32'(sat_flag),  32'd0);
        chk("rst_sat_cnt",   32'(sat_cnt),   32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        tick();
        tick();
        rst_n = 1'b1;

        // Identity twiddle, two-edge latency
        send(24'h100080, 24'h400000);
        chk("id_latency", 32'(out_valid), 32'd0);
        tick();
        chk("id_valid", 32'(out_valid), 32'd1);
        chk("id_out",   32'(dout),      32'h100080);
        chk("id_sat",   32'(sat_flag),  32'd0);
        tick();
        chk("id_bubble", 32'(out_valid), 32'd0);

        // Twiddle j: (256,128)*conj(j) = (128,-256)
        send(24'h100080, 24'h000400);
        tick();
        chk("j_out", 32'(dout), 32'h080F00);

        // Saturation of the imaginary part
        send(24'h7FF7FF, 24'h400C00);
        tick();
        chk("sat_out",  32'(dout),     32'h0007FF);
        chk("sat_flag", 32'(sat_flag), 32'd1);
        chk("sat_cnt0", 32'(sat_cnt),  32'd0);
        tick();
        chk("sat_cnt1", 32'(sat_cnt),   32'd1);
        chk("sat_done", 32'(out_valid), 32'd0);

        // Rounding, back-to-back: 512/1024 -> 1 and -512/1024 -> 0
        send(24'h001000, 24'h200000);
        send(24'hFFF000, 24'h200000);
        chk("rnd_pos", 32'(dout), 32'h001000);
        tick();
        chk("rnd_neg_v", 32'(out_valid), 32'd1);
        chk("rnd_neg",   32'(dout),      32'h000000);
        tick();
        chk("rnd_end", 32'(out_valid), 32'd0);

        // Stream of four with a stall after the first result
        in_valid = 1'b1;
        c = 24'h100080; t = 24'h400000;
        tick();
        c = 24'h001000; t = 24'h400000;
        tick();
        chk("st_a_v", 32'(out_valid), 32'd1);
        chk("st_a",   32'(dout),      32'h100080);
        out_ready = 1'b0;
        #1;
        chk("st_in_ready0", 32'(in_ready), 32'd0);
        c = 24'h002003; t = 24'h400000;
        tick();
        chk("st_hold1", 32'(dout),      32'h100080);
        chk("st_hold1v", 32'(out_valid), 32'd1);
        tick();
        chk("st_hold2", 32'(dout), 32'h100080);
        chk("st_cnt_hold", 32'(sat_cnt), 32'd1);
        out_ready = 1'b1;
        #1;
        chk("st_in_ready1", 32'(in_ready), 32'd1);
        tick();
        chk("st_b", 32'(dout), 32'h001000);
        c = 24'h100080; t = 24'h000400;
        tick();
        chk("st_c", 32'(dout), 32'h002003);
        in_valid = 1'b0;
        tick();
        chk("st_d_v", 32'(out_valid), 32'd1);
        chk("st_d",   32'(dout),      32'h080F00);
        tick();
        chk("st_end", 32'(out_valid), 32'd0);

        // Reset with two results in flight
        out_ready = 1'b0;
        send(24'h7FF7FF, 24'h400C00);
        send(24'h100080, 24'h400000);
        chk("fl_v",   32'(out_valid), 32'd1);
        chk("fl_sat", 32'(sat_flag),  32'd1);
        rst_n = 1'b0;
        #1;
        chk("fl_rst_v",   32'(out_valid), 32'd0);
        chk("fl_rst_out", 32'(dout),      32'h000000);
        chk("fl_rst_sat", 32'(sat_flag),  32'd0);
        chk("fl_rst_cnt", 32'(sat_cnt),   32'd0);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        tick();
        chk("fl_post1", 32'(out_valid), 32'd0);
        tick();
        chk("fl_post2", 32'(out_valid), 32'd0);

        // First edge after release accepts
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        send(24'h100080, 24'h000400);
        tick();
        chk("first_v",   32'(out_valid), 32'd1);
        chk("first_out", 32'(dout),      32'h080F00);
        chk("first_cnt", 32'(sat_cnt),   32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
